// File: rtl/idex_stage_pkg.sv
// Shared pipeline-register definitions: register-zero constant, EX/MEM control
// bundle layout and the ID/EX field list with its bubble value.
package idex_stage_pkg;

   localparam int unsigned PIPE_REG_AW = 6;
   localparam int unsigned PIPE_DATA_W = 32;
   localparam int unsigned PIPE_CTRL_W = 8;

   localparam logic [PIPE_REG_AW-1:0] REG_ZERO = '0;

   // EX/MEM control bundle layout; opaque to the ID/EX register itself
   localparam int unsigned CTRL_ALUOP_LSB    = 0;
   localparam int unsigned CTRL_ALUOP_W      = 4;
   localparam int unsigned CTRL_ALUSRC_BIT   = 4;
   localparam int unsigned CTRL_MEMTOREG_BIT = 5;
   localparam int unsigned CTRL_BRANCH_BIT   = 6;
   localparam int unsigned CTRL_JUMP_BIT     = 7;

   typedef struct packed {
      logic                   valid;
      logic [PIPE_REG_AW-1:0] rs;
      logic [PIPE_REG_AW-1:0] rt;
      logic [PIPE_REG_AW-1:0] rdes;
      logic                   regwr;
      logic                   memrd;
      logic                   memwr;
      logic [PIPE_CTRL_W-1:0] ctrl;
      logic [PIPE_DATA_W-1:0] opa;
      logic [PIPE_DATA_W-1:0] opb;
      logic [PIPE_DATA_W-1:0] imm;
   } idex_t;

   localparam idex_t IDEX_BUBBLE = '0;

endpackage

// File: rtl/idex_stage_load_use_detect.sv
// Load-use hazard compare: a load in ID/EX whose destination feeds the
// instruction currently in ID.
module idex_stage_load_use_detect
   import idex_stage_pkg::*;
#(
   parameter int unsigned REG_AW = 6
) (
   input  logic              idex_valid,
   input  logic              idex_memrd,
   input  logic [REG_AW-1:0] idex_rdes,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rt,
   output logic              luh
);

   logic rs_hit;
   logic rt_hit;

   always_comb begin
      rs_hit = (idex_rdes == id_rs);
      rt_hit = id_uses_rt & (idex_rdes == id_rt);
      luh    = idex_valid & idex_memrd & (idex_rdes != REG_AW'(REG_ZERO)) & id_valid
               & (rs_hit | rt_hit);
   end

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use stall: inserts one bubble per dependent
// load/use pair, honouring EX flush (highest) and EX hold.
module idex_stage
   import idex_stage_pkg::*;
#(
   parameter int unsigned REG_AW = 6,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CTRL_W = 8,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rt,
   input  logic [REG_AW-1:0] id_rdes,
   input  logic              id_regwr,
   input  logic              id_memrd,
   input  logic              id_memwr,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [DATA_W-1:0] id_opa,
   input  logic [DATA_W-1:0] id_opb,
   input  logic [DATA_W-1:0] id_imm,
   input  logic              ex_hold,
   input  logic              ex_flush,
   output logic              stall_fe,
   output logic              idex_valid,
   output logic [REG_AW-1:0] idex_rs,
   output logic [REG_AW-1:0] idex_rt,
   output logic [REG_AW-1:0] idex_rdes,
   output logic              idex_regwr,
   output logic              idex_memrd,
   output logic              idex_memwr,
   output logic [CTRL_W-1:0] idex_ctrl,
   output logic [DATA_W-1:0] idex_opa,
   output logic [DATA_W-1:0] idex_opb,
   output logic [DATA_W-1:0] idex_imm,
   output logic [CNT_W-1:0]  bubble_cnt
);

   logic luh;

   idex_stage_load_use_detect #(
      .REG_AW (REG_AW)
   ) u_luh (
      .idex_valid (idex_valid),
      .idex_memrd (idex_memrd),
      .idex_rdes  (idex_rdes),
      .id_valid   (id_valid),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_uses_rt (id_uses_rt),
      .luh        (luh)
   );

   always_comb begin
      stall_fe = (luh | ex_hold) & ~ex_flush;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idex_valid <= 1'b0;
         idex_rs    <= '0;
         idex_rt    <= '0;
         idex_rdes  <= '0;
         idex_regwr <= 1'b0;
         idex_memrd <= 1'b0;
         idex_memwr <= 1'b0;
         idex_ctrl  <= '0;
         idex_opa   <= '0;
         idex_opb   <= '0;
         idex_imm   <= '0;
         bubble_cnt <= '0;
      end else if (ex_flush || (!ex_hold && luh)) begin
         // Bubble: zero specifiers keep ForwardUnit quiet, zero enables kill side effects
         idex_valid <= 1'b0;
         idex_rs    <= '0;
         idex_rt    <= '0;
         idex_rdes  <= '0;
         idex_regwr <= 1'b0;
         idex_memrd <= 1'b0;
         idex_memwr <= 1'b0;
         idex_ctrl  <= '0;
         idex_opa   <= '0;
         idex_opb   <= '0;
         idex_imm   <= '0;
         if (!ex_flush && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + 1'b1;
         end
      end else if (!ex_hold) begin
         idex_valid <= id_valid;
         idex_rs    <= id_rs;
         idex_rt    <= id_rt;
         idex_rdes  <= id_rdes;
         idex_regwr <= id_regwr & id_valid;
         idex_memrd <= id_memrd & id_valid;
         idex_memwr <= id_memwr & id_valid;
         idex_ctrl  <= id_ctrl;
         idex_opa   <= id_opa;
         idex_opb   <= id_opb;
         idex_imm   <= id_imm;
      end
   end

endmodule

// File: tb/tb_idex_stage.sv
// Directed bench for idex_stage: reset, load-use bubble, false-stall cases,
// flush priority, hold, and 4-bit counter saturation.
module tb_idex_stage;

   logic        clk;
   logic        reset_n;
   logic        id_valid;
   logic [5:0]  id_rs;
   logic [5:0]  id_rt;
   logic        id_uses_rt;
   logic [5:0]  id_rdes;
   logic        id_regwr;
   logic        id_memrd;
   logic        id_memwr;
   logic [7:0]  id_ctrl;
   logic [31:0] id_opa;
   logic [31:0] id_opb;
   logic [31:0] id_imm;
   logic        ex_hold;
   logic        ex_flush;
   logic        stall_fe;
   logic        idex_valid;
   logic [5:0]  idex_rs;
   logic [5:0]  idex_rt;
   logic [5:0]  idex_rdes;
   logic        idex_regwr;
   logic        idex_memrd;
   logic        idex_memwr;
   logic [7:0]  idex_ctrl;
   logic [31:0] idex_opa;
   logic [31:0] idex_opb;
   logic [31:0] idex_imm;
   logic [3:0]  bubble_cnt;

   int vectors;
   int miscompares;

   idex_stage #(
      .REG_AW (6),
      .DATA_W (32),
      .CTRL_W (8),
      .CNT_W  (4)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .id_valid   (id_valid),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_uses_rt (id_uses_rt),
      .id_rdes    (id_rdes),
      .id_regwr   (id_regwr),
      .id_memrd   (id_memrd),
      .id_memwr   (id_memwr),
      .id_ctrl    (id_ctrl),
      .id_opa     (id_opa),
      .id_opb     (id_opb),
      .id_imm     (id_imm),
      .ex_hold    (ex_hold),
      .ex_flush   (ex_flush),
      .stall_fe   (stall_fe),
      .idex_valid (idex_valid),
      .idex_rs    (idex_rs),
      .idex_rt    (idex_rt),
      .idex_rdes  (idex_rdes),
      .idex_regwr (idex_regwr),
      .idex_memrd (idex_memrd),
      .idex_memwr (idex_memwr),
      .idex_ctrl  (idex_ctrl),
      .idex_opa   (idex_opa),
      .idex_opb   (idex_opb),
      .idex_imm   (idex_imm),
      .bubble_cnt (bubble_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Operand data derived from rs so each instruction is distinguishable
   task automatic set_id(input logic v, input logic [5:0] rs, input logic [5:0] rt,
                         input logic ur, input logic [5:0] rd, input logic rw,
                         input logic mr, input logic mw);
      id_valid   = v;
      id_rs      = rs;
      id_rt      = rt;
      id_uses_rt = ur;
      id_rdes    = rd;
      id_regwr   = rw;
      id_memrd   = mr;
      id_memwr   = mw;
      id_ctrl    = {2'b01, rs};
      id_opa     = 32'h1000_0000 + 32'(rs);
      id_opb     = 32'h2000_0000 + 32'(rt);
      id_imm     = 32'h0000_0100 + 32'(rd);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int exp_cnt;
      vectors     = 0;
      miscompares = 0;
      reset_n     = 1'b0;
      ex_hold     = 1'b0;
      ex_flush    = 1'b0;
      set_id(1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      chk("rst_valid", 32'(idex_valid), 32'd0);
      chk("rst_cnt", 32'(bubble_cnt), 32'd0);
      chk("rst_stall", 32'(stall_fe), 32'd0);
      reset_n = 1'b1;

      // Load-use on rs
      set_id(1'b1, 6'd1, 6'd5, 1'b0, 6'd5, 1'b1, 1'b1, 1'b0);
      tick();
      chk("lw_memrd", 32'(idex_memrd), 32'd1);
      chk("lw_rdes", 32'(idex_rdes), 32'd5);
      chk("lw_opa", idex_opa, 32'h1000_0001);
      set_id(1'b1, 6'd5, 6'd2, 1'b1, 6'd7, 1'b1, 1'b0, 1'b0);
      #1;
      chk("luh_stall", 32'(stall_fe), 32'd1);
      tick();
      chk("bub_valid", 32'(idex_valid), 32'd0);
      chk("bub_regwr", 32'(idex_regwr), 32'd0);
      chk("bub_cnt", 32'(bubble_cnt), 32'd1);
      chk("bub_stall_clr", 32'(stall_fe), 32'd0);
      tick();
      chk("add_rs", 32'(idex_rs), 32'd5);
      chk("add_valid", 32'(idex_valid), 32'd1);
      chk("add_stall", 32'(stall_fe), 32'd0);

      // No stall: load to r0
      set_id(1'b1, 6'd2, 6'd0, 1'b0, 6'd0, 1'b1, 1'b1, 1'b0);
      tick();
      set_id(1'b1, 6'd0, 6'd0, 1'b1, 6'd8, 1'b1, 1'b0, 1'b0);
      #1;
      chk("r0_stall", 32'(stall_fe), 32'd0);
      tick();
      chk("r0_valid", 32'(idex_valid), 32'd1);
      chk("r0_cnt", 32'(bubble_cnt), 32'd1);

      // No stall: rt match but rt unused
      set_id(1'b1, 6'd2, 6'd0, 1'b0, 6'd5, 1'b1, 1'b1, 1'b0);
      tick();
      set_id(1'b1, 6'd3, 6'd5, 1'b0, 6'd6, 1'b1, 1'b0, 1'b0);
      #1;
      chk("rtun_stall", 32'(stall_fe), 32'd0);
      tick();
      chk("rtun_valid", 32'(idex_valid), 32'd1);
      chk("rtun_rt", 32'(idex_rt), 32'd5);

      // No stall: rdes match on a non-load (rdes=6 now in ID/EX)
      set_id(1'b1, 6'd6, 6'd1, 1'b1, 6'd9, 1'b1, 1'b0, 1'b0);
      #1;
      chk("nold_stall", 32'(stall_fe), 32'd0);
      tick();
      chk("nold_rs", 32'(idex_rs), 32'd6);
      chk("nold_cnt", 32'(bubble_cnt), 32'd1);

      // rt dependence with uses_rt=1 does stall
      set_id(1'b1, 6'd1, 6'd0, 1'b0, 6'd11, 1'b1, 1'b1, 1'b0);
      tick();
      set_id(1'b1, 6'd2, 6'd11, 1'b1, 6'd0, 1'b0, 1'b0, 1'b1);
      #1;
      chk("rtuse_stall", 32'(stall_fe), 32'd1);
      tick();
      chk("rtuse_cnt", 32'(bubble_cnt), 32'd2);
      tick();
      chk("sw_memwr", 32'(idex_memwr), 32'd1);

      // Flush beats load-use
      set_id(1'b1, 6'd1, 6'd0, 1'b0, 6'd9, 1'b1, 1'b1, 1'b0);
      tick();
      set_id(1'b1, 6'd9, 6'd3, 1'b1, 6'd10, 1'b1, 1'b0, 1'b0);
      ex_flush = 1'b1;
      #1;
      chk("flush_stall", 32'(stall_fe), 32'd0);
      tick();
      ex_flush = 1'b0;
      chk("flush_valid", 32'(idex_valid), 32'd0);
      chk("flush_regwr", 32'(idex_regwr), 32'd0);
      chk("flush_cnt", 32'(bubble_cnt), 32'd2);
      tick();
      chk("postfl_rs", 32'(idex_rs), 32'd9);

      // Hold for 3 cycles while ID changes
      ex_hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_id(1'b1, 6'(20 + i), 6'd1, 1'b1, 6'd2, 1'b1, 1'b0, 1'b0);
         #1;
         chk("hold_stall", 32'(stall_fe), 32'd1);
         tick();
         chk("hold_rs", 32'(idex_rs), 32'd9);
         chk("hold_opa", idex_opa, 32'h1000_0009);
      end
      ex_hold = 1'b0;
      set_id(1'b1, 6'd12, 6'd1, 1'b1, 6'd13, 1'b1, 1'b0, 1'b0);
      #1;
      chk("rel_stall", 32'(stall_fe), 32'd0);
      tick();
      chk("rel_rs", 32'(idex_rs), 32'd12);
      chk("rel_opa", idex_opa, 32'h1000_000c);

      // 20 isolated load-use events; 4-bit counter must stop at 15
      exp_cnt = 2;
      for (int i = 0; i < 20; i++) begin
         set_id(1'b1, 6'd1, 6'd0, 1'b0, 6'd4, 1'b1, 1'b1, 1'b0);
         tick();
         set_id(1'b1, 6'd4, 6'd0, 1'b0, 6'd7, 1'b1, 1'b0, 1'b0);
         tick();
         if (exp_cnt < 15) exp_cnt++;
         chk("sat_cnt", 32'(bubble_cnt), 32'(exp_cnt));
         tick();
      end
      chk("sat_final", 32'(bubble_cnt), 32'd15);

      // Async reset mid-stream, checked before the next edge
      chk("pre_rst_regwr", 32'(idex_regwr), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("arst_regwr", 32'(idex_regwr), 32'd0);
      chk("arst_valid", 32'(idex_valid), 32'd0);
      chk("arst_rs", 32'(idex_rs), 32'd0);
      chk("arst_opa", idex_opa, 32'd0);
      chk("arst_cnt", 32'(bubble_cnt), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
